// File: rtl/led7seg_pkg.sv
// Shared constants and types for the four-digit multiplexed 7-segment scanner.
// Glyphs are active-low, bit order g..a.
package led7seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] SA_OFF  = 4'b1111;
    localparam logic [6:0] SEG_NONE = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

endpackage

// File: rtl/led7seg_dec.sv
// Combinational hex to active-low 7-segment decoder (g..a), no latency.
// No flow control; output follows input in the same cycle.
module led7seg_dec (
    input  logic [3:0] value,
    output logic [6:0] seg
);
    import led7seg_pkg::*;

    always_comb begin
        seg = GLYPH_0;
        case (value)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = GLYPH_0;
        endcase
    end

endmodule

// File: rtl/led7seg_scan.sv
// Four-digit multiplexed 7-segment scanner with blanking gap; outputs registered (1 cycle).
// Writes always accepted, no back-pressure. Define LED7SEG_LZB_EN for leading-zero blanking.
module led7seg_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       WE,
    input  logic [1:0] WADDR,
    input  logic [3:0] WDATA,
    input  logic       WDP,
    output logic [3:0] SA,
    output logic [7:0] LED
);
    import led7seg_pkg::*;

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    scan_state_t     state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      idx, idx_nxt;
    logic [3:0][3:0] val;
    logic [3:0]      dp;
    logic [6:0]      seg;
    logic            lead_zero;
    logic [3:0]      sa_nxt;
    logic [7:0]      led_nxt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= SHOW;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        case (state)
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 2'd1;
                end
            end
            default: begin
                state_nxt = SHOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            val <= '0;
            dp  <= '0;
        end else if (WE) begin
            val[WADDR] <= WDATA;
            dp[WADDR]  <= WDP;
        end
    end

    led7seg_dec u_dec (
        .value (val[idx]),
        .seg   (seg)
    );

`ifdef LED7SEG_LZB_EN
    // A digit is a leading zero when it and every more-significant digit are 0.
    always_comb begin
        lead_zero = (idx != 2'd0);
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(idx) && val[i] != 4'h0) begin
                lead_zero = 1'b0;
            end
        end
    end
`else
    assign lead_zero = 1'b0;
`endif

    always_comb begin
        sa_nxt  = SA_OFF;
        led_nxt = SEG_OFF;
        if (state == SHOW && EN) begin
            sa_nxt  = ~(4'b0001 << idx);
            led_nxt = {~dp[idx], (lead_zero ? SEG_NONE : seg)};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            SA  <= SA_OFF;
            LED <= SEG_OFF;
        end else begin
            SA  <= sa_nxt;
            LED <= led_nxt;
        end
    end

endmodule
